// File: rtl/uart_apb_tx_scheduler_if.sv
// uart_apb_tx_scheduler_if: requester handshake plus the APB master bus of the scheduler.
interface uart_apb_tx_scheduler_if #(parameter int N = 2);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [31:0]    m_paddr;
  logic           m_psel;
  logic           m_penable;
  logic           m_pwrite;
  logic [31:0]    m_pwdata;
  logic [31:0]    m_prdata;
  logic           m_pready;
  modport master (
    input  req_valid, req_data, m_prdata, m_pready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
  );
  modport slave (
    output req_valid, req_data, m_prdata, m_pready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           m_paddr, m_psel, m_penable, m_pwrite, m_pwdata
  );
endinterface

// File: rtl/uart_apb_tx_scheduler.sv
// uart_apb_tx_scheduler: round-robin sharing of the APB UART loopback block among N byte producers.
module uart_apb_tx_scheduler #(
  parameter int N          = 2,
  parameter int POLL_LIMIT = 4096
) (
  input logic                        PCLK,
  input logic                        PRESETn,
  uart_apb_tx_scheduler_if.master    bus
);
  localparam int CW = $clog2(POLL_LIMIT);
  typedef enum logic [3:0] {
    INIT, IDLE, WR_DATA, WR_GO, POLL_TX, WR_STOP, POLL_RX, RD_RX, RESP, REC_RST, REC_EN
  } state_t;
  state_t        r_state, w_state;
  logic          r_psel, r_pen, w_psel, w_pen;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_last, r_id, w_gnt, w_gnt_hi, w_gnt_lo;
  logic [7:0]    r_byte, r_data, w_byte;
  logic          r_err, w_any_hi, w_grant, w_done, w_poll_last, w_wr;
  logic [1:0]    w_addr;
  logic [31:0]   w_wdata;
  // Prefer the lowest requester above the last grant, else wrap to the lowest one overall.
  always_comb begin
    w_gnt_hi = '0;
    w_gnt_lo = '0;
    w_any_hi = 1'b0;
    w_byte   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) w_gnt_lo = 2'(i);
      if (bus.req_valid[i] && i > int'(r_last)) begin
        w_gnt_hi = 2'(i);
        w_any_hi = 1'b1;
      end
    end
    w_gnt = w_any_hi ? w_gnt_hi : w_gnt_lo;
    for (int i = 0; i < N; i++) if (w_gnt == 2'(i)) w_byte = bus.req_data[8*i +: 8];
  end
  assign w_grant     = (r_state == IDLE) && |bus.req_valid;
  assign w_done      = r_psel & r_pen & bus.m_pready;
  assign w_poll_last = r_cnt == CW'(POLL_LIMIT - 1);
  always_comb begin
    w_state = r_state;
    case (r_state)
      INIT:    w_state = w_done ? IDLE : INIT;
      IDLE:    w_state = w_grant ? WR_DATA : IDLE;
      WR_DATA: w_state = w_done ? WR_GO : WR_DATA;
      WR_GO:   w_state = w_done ? POLL_TX : WR_GO;
      POLL_TX: w_state = !w_done ? POLL_TX : bus.m_prdata[1] ? WR_STOP : w_poll_last ? REC_RST : POLL_TX;
      WR_STOP: w_state = w_done ? POLL_RX : WR_STOP;
      POLL_RX: w_state = !w_done ? POLL_RX : bus.m_prdata[3] ? RD_RX : w_poll_last ? REC_RST : POLL_RX;
      RD_RX:   w_state = w_done ? RESP : RD_RX;
      REC_RST: w_state = w_done ? REC_EN : REC_RST;
      REC_EN:  w_state = w_done ? RESP : REC_EN;
      RESP:    w_state = IDLE;
      default: w_state = INIT;
    endcase
  end
  // A finished op flows straight into the next op's SETUP, so penable never stays high across ops.
  assign w_pen  = r_psel & (~r_pen | ~bus.m_pready);
  assign w_psel = (r_psel & ~w_done) | ~(w_state == IDLE || w_state == RESP);
  always_comb begin
    w_addr  = 2'd0;
    w_wr    = 1'b1;
    w_wdata = 32'h4;
    case (r_state)
      WR_DATA: begin
        w_addr  = 2'd2;
        w_wdata = {24'b0, r_byte};
      end
      WR_GO:   w_wdata = 32'h5;
      REC_RST: w_wdata = 32'hF;
      POLL_TX, POLL_RX: begin
        w_addr = 2'd1;
        w_wr   = 1'b0;
      end
      RD_RX: begin
        w_addr = 2'd3;
        w_wr   = 1'b0;
      end
      default: w_wdata = 32'h4;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= INIT;
      r_psel  <= 1'b0;
      r_pen   <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 2'(N - 1);
      r_id    <= '0;
      r_byte  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_psel  <= w_psel;
      r_pen   <= w_pen;
      r_cnt   <= (w_state != r_state) ? '0 : w_done ? r_cnt + CW'(1) : r_cnt;
      if (w_grant) begin
        r_last <= w_gnt;
        r_id   <= w_gnt;
        r_byte <= w_byte;
      end
      if (r_state == POLL_RX && w_done && bus.m_prdata[3]) r_err <= bus.m_prdata[4];
      if (r_state == RD_RX && w_done) r_data <= bus.m_prdata[7:0];
      if (w_state == REC_RST && r_state != REC_RST) begin
        r_err  <= 1'b1;
        r_data <= '0;
      end
    end
  end
  assign bus.req_ready = w_grant ? N'(1) << w_gnt : '0;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = r_state != IDLE;
  assign bus.m_psel    = r_psel;
  assign bus.m_penable = r_pen;
  assign bus.m_paddr   = r_psel ? {30'b0, w_addr} : '0;
  assign bus.m_pwrite  = r_psel & w_wr;
  assign bus.m_pwdata  = (r_psel && w_wr) ? w_wdata : '0;
endmodule
